// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg : shared RV32I opcodes, control FSM states and datapath mux codes
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_PC  = 4'd4,
    ST_WB_ALU   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JAL      = 4'd11,
    ST_JALR     = 4'd12,
    ST_WB_IMM   = 4'd13,
    ST_TRAP     = 4'd14
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WBS_ALU = 2'd0,
    WBS_MDR = 2'd1,
    WBS_PC4 = 2'd2,
    WBS_IMM = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_CMP   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    TC_NONE        = 2'd0,
    TC_ILLEGAL     = 2'd1,
    TC_MEM_TIMEOUT = 2'd2
  } trap_cause_e;

  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    mem_addr_src;
    logic    ir_write;
    logic    mdr_write;
    logic    pc_write;
    pc_src_e pc_src;
    logic    alu_a_src;
    logic    alu_b_src;
    alu_op_e alu_op;
    logic    reg_write;
    wb_src_e wb_src;
  } ctrl_t;

  function automatic state_e dispatch(input logic [6:0] opcode);
    state_e s;
    unique case (opcode)
      c_OPC_OP:               s = ST_EXEC_R;
      c_OPC_OP_IMM:           s = ST_EXEC_I;
      c_OPC_LOAD, c_OPC_STORE: s = ST_MEM_ADDR;
      c_OPC_BRANCH:           s = ST_BRANCH;
      c_OPC_JAL:              s = ST_JAL;
      c_OPC_JALR:             s = ST_JALR;
      c_OPC_LUI:              s = ST_WB_IMM;
      c_OPC_AUIPC:            s = ST_EXEC_PC;
      default:                s = ST_TRAP;
    endcase
    return s;
  endfunction

  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if : control bus between the main FSM and the datapath
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface multicycle_controller_if;

  logic [6:0] opcode;
  logic       branch_cond;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_src;
  logic       ir_write;
  logic       mdr_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_a_src;
  logic       alu_b_src;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_src;
  logic       instr_retired;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, branch_cond, mem_ready,
    output mem_req, mem_we, mem_addr_src, ir_write, mdr_write, pc_write,
           pc_src, alu_a_src, alu_b_src, alu_op, reg_write, wb_src,
           instr_retired, trap, trap_cause
  );

  modport slave (
    output opcode, branch_cond, mem_ready,
    input  mem_req, mem_we, mem_addr_src, ir_write, mdr_write, pc_write,
           pc_src, alu_a_src, alu_b_src, alu_op, reg_write, wb_src,
           instr_retired, trap, trap_cause
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_controller_mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog : counts stalled memory-request cycles and flags the timeout
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic timeout_o
);

  if (MEM_TIMEOUT != 0) begin : g_wd_on
    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst || clear_i) begin
        cnt_q <= '0;
      end else if (count_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + TO_W'(1);
      end
    end

    assign timeout_o = (cnt_q == TO_W'(MEM_TIMEOUT));
  end else begin : g_wd_off
    logic unused_wd;
    assign unused_wd = clk ^ rst ^ clear_i ^ count_i;
    assign timeout_o = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller : RV32I multi-cycle main control FSM
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus_if
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  ctrl_t       w_ctrl, w_out;
  logic        w_in_mem;
  logic        w_stall_trap;
  logic        w_wd_clear;
  logic        w_wd_count;
  logic        w_wd_timeout;

  assign w_in_mem     = is_mem_state(state_q);
  assign w_stall_trap = w_in_mem && !bus_if.mem_ready && w_wd_timeout;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (w_stall_trap) begin
      state_d = ST_TRAP;
      cause_d = TC_MEM_TIMEOUT;
    end else begin
      unique case (state_q)
        ST_FETCH:    if (bus_if.mem_ready) state_d = ST_DECODE;
        ST_DECODE: begin
          state_d = dispatch(bus_if.opcode);
          if (state_d == ST_TRAP) cause_d = TC_ILLEGAL;
        end
        ST_EXEC_R, ST_EXEC_I, ST_EXEC_PC: state_d = ST_WB_ALU;
        // opcode[5] is the only bit separating STORE from LOAD
        ST_MEM_ADDR: state_d = bus_if.opcode[5] ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (bus_if.mem_ready) state_d = ST_WB_MEM;
        ST_MEM_WR:   if (bus_if.mem_ready) state_d = ST_FETCH;
        ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR, ST_WB_IMM:
          state_d = ST_FETCH;
        ST_TRAP:     state_d = ST_TRAP;
        default:     state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    w_ctrl = '0;
    unique case (state_q)
      ST_FETCH: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.ir_write = bus_if.mem_ready;
      end
      ST_EXEC_R: begin
        w_ctrl.alu_op = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_b_src = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_PC, ST_MEM_ADDR: begin
        w_ctrl.alu_a_src = (state_q == ST_EXEC_PC);
        w_ctrl.alu_b_src = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      ST_WB_ALU, ST_WB_MEM, ST_WB_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_src    = PC_PLUS4;
        w_ctrl.wb_src    = (state_q == ST_WB_ALU) ? WBS_ALU :
                           (state_q == ST_WB_MEM) ? WBS_MDR : WBS_IMM;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_req      = 1'b1;
        w_ctrl.mem_addr_src = 1'b1;
        w_ctrl.mdr_write    = bus_if.mem_ready;
      end
      ST_MEM_WR: begin
        w_ctrl.mem_req      = 1'b1;
        w_ctrl.mem_we       = 1'b1;
        w_ctrl.mem_addr_src = 1'b1;
        w_ctrl.pc_write     = bus_if.mem_ready;
        w_ctrl.pc_src       = PC_PLUS4;
      end
      ST_BRANCH: begin
        w_ctrl.alu_op   = ALU_CMP;
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = bus_if.branch_cond ? PC_IMM : PC_PLUS4;
      end
      ST_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_src    = WBS_PC4;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_src    = PC_IMM;
      end
      ST_JALR: begin
        w_ctrl.alu_b_src = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_src    = WBS_PC4;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_src    = PC_ALU;
      end
      default: w_ctrl = '0;
    endcase
    // reset kills every strobe combinationally, aborting any in-flight access
    w_out = rst ? '0 : w_ctrl;
  end

  assign w_wd_clear = !w_in_mem || (state_d != state_q);
  assign w_wd_count = w_out.mem_req && !bus_if.mem_ready;

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_mem_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_wd_clear),
    .count_i  (w_wd_count),
    .timeout_o(w_wd_timeout)
  );

  assign bus_if.mem_req       = w_out.mem_req;
  assign bus_if.mem_we        = w_out.mem_we;
  assign bus_if.mem_addr_src  = w_out.mem_addr_src;
  assign bus_if.ir_write      = w_out.ir_write;
  assign bus_if.mdr_write     = w_out.mdr_write;
  assign bus_if.pc_write      = w_out.pc_write;
  assign bus_if.pc_src        = w_out.pc_src;
  assign bus_if.alu_a_src     = w_out.alu_a_src;
  assign bus_if.alu_b_src     = w_out.alu_b_src;
  assign bus_if.alu_op        = w_out.alu_op;
  assign bus_if.reg_write     = w_out.reg_write;
  assign bus_if.wb_src        = w_out.wb_src;
  assign bus_if.instr_retired = w_out.pc_write;
  assign bus_if.trap          = !rst && (state_q == ST_TRAP);
  assign bus_if.trap_cause    = rst ? 2'd0 : cause_q;

endmodule

`default_nettype wire
